// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - port_e     : index of the two masters sharing the data memory
//   - TYPE_*     : 3-bit access-type codes, same encoding as the CPU Type field
//                  and the memory unit (byte/half/word, signed/unsigned)
//   - CNT_W      : width of the port-1 starvation counter
//   - is_load()  : helper that qualifies an issued access as a load
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  localparam logic [2:0] TYPE_B  = 3'b000;
  localparam logic [2:0] TYPE_H  = 3'b001;
  localparam logic [2:0] TYPE_W  = 3'b010;
  localparam logic [2:0] TYPE_BU = 3'b100;
  localparam logic [2:0] TYPE_HU = 3'b101;

  localparam int CNT_W = 4;

  function automatic logic is_load(input logic en, input logic we);
    return en & ~we;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_cnt
// Saturating counter used to bound how long port 1 can be starved.
// Ports:
//   CLK      in   clock
//   rst      in   asynchronous active-low reset (count cleared)
//   inc      in   count one more lost cycle
//   clr      in   clear the count (has priority over inc)
//   sat_val  in   saturation value
//   cnt      out  current count
//   sat      out  count has reached sat_val
// -----------------------------------------------------------------------------
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] sat_val,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  // >= rather than == keeps the counter stuck at the limit even if sat_val
  // were ever lowered below the current count.
  assign sat = (cnt >= sat_val);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares one data memory (1-cycle synchronous read, write-first) between the
// CPU load/store path (port 0) and a debug/program-loader master (port 1).
// Port 0 has fixed priority; port 1 is forced through once it has lost
// MAX_WAIT conflicting cycles. One access is issued per cycle and load data
// is routed back to the issuing port one cycle after its grant.
//
// Handshake: a master raises reqN with weN/addrN/wdataN/typeN stable and holds
// them until gntN is seen high in the same cycle; gntN marks the cycle the
// access is issued to memory. A store is complete at its grant. A load returns
// rdataN qualified by rvalidN exactly one cycle after its grant. rvalidN has
// no back-pressure.
//
// Ports:
//   CLK, rst                 clock, asynchronous active-low reset
//   req/we/addr/wdata/type 0,1   request fields of port 0 (CPU) and port 1 (debug)
//   gnt0, gnt1               access issued this cycle (combinational)
//   rvalid0/1, rdata0/1      registered load return (rdata is 0 when not valid)
//   mem_en/we/addr/wdata/type    access to the memory (all 0 when idle)
//   mem_rdata                memory read data, valid the cycle after a load
//   wait_sat                 port-1 starvation counter at MAX_WAIT
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
)(
  input  logic             CLK,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [2:0]       type0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [2:0]       type1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [2:0]       mem_type,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             wait_sat
);

  localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             cnt_sat;
  logic             cnt_inc;
  logic             rd_pend;
  port_e            rd_owner;

  // ---------------------------------------------------------------------------
  // Grant: port 0 wins conflicts unless port 1 has waited MAX_WAIT cycles.
  // Everything is gated by rst so no access leaks out while in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (req1 && (!req0 || cnt_sat)) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  // Only cycles where port 1 actually asks and loses are counted; a dropped
  // request leaves the count where it was.
  assign cnt_inc  = req1 & ~gnt1;
  assign wait_sat = rst & cnt_sat;

  mem_arb_starve_cnt u_starve_cnt (
    .CLK     (CLK),
    .rst     (rst),
    .inc     (cnt_inc),
    .clr     (gnt1),
    .sat_val (SAT_VAL),
    .cnt     (wait_cnt),
    .sat     (cnt_sat)
  );

  // ---------------------------------------------------------------------------
  // Field mux toward memory; idle cycles drive zeros so the bus is quiet.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_type  = '0;
    if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_type  = type1;
    end else if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_type  = type0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: remember whether the issued access was a load and who owns
  // it. A new load may be issued in the same cycle the previous one returns.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= PORT_CPU;
    end else begin
      rd_pend <= is_load(mem_en, mem_we);
      if (is_load(mem_en, mem_we)) begin
        rd_owner <= gnt1 ? PORT_DBG : PORT_CPU;
      end
    end
  end

  assign rvalid0 = rd_pend & (rd_owner == PORT_CPU);
  assign rvalid1 = rd_pend & (rd_owner == PORT_DBG);
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a behavioural write-first memory,
// a reference memory image and per-port expected-data queues.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int W  = 32;
  localparam int MW = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  logic         req0, we0, req1, we1;
  logic [W-1:0] addr0, wdata0, addr1, wdata1;
  logic [2:0]   type0, type1;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0] rdata0, rdata1;
  logic         mem_en, mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]   mem_type;
  logic         wait_sat;

  data_mem_arbiter #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .type0(type0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .type1(type1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_rdata(mem_rdata),
    .wait_sat(wait_sat)
  );

  // ---------------------------------------------------------------------------
  // Memory: write-first, 1-cycle read latency, preload port for setup
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem [0:255];
  logic         pl_we;
  logic [7:0]   pl_idx;
  logic [W-1:0] pl_dat;

  always @(posedge CLK) begin
    if (pl_we) begin
      mem[pl_idx] <= pl_dat;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] ref_mem [0:255];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic         pend0, pend1;
  int           checks, errors;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one cycle. Called at a negedge; drives, samples #1 later,
  // checks, updates the model, and returns at the next negedge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic r0, input logic w0, input logic [W-1:0] a0, input logic [W-1:0] d0,
                      input logic r1, input logic w1, input logic [W-1:0] a1, input logic [W-1:0] d1,
                      input logic eg0, input logic eg1, input logic esat, input logic push);
    logic [W-1:0] e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    chk("gnt0", 32'(gnt0), 32'(eg0));
    chk("gnt1", 32'(gnt1), 32'(eg1));
    chk("mem_en", 32'(mem_en), 32'(eg0 | eg1));
    chk("wait_sat", 32'(wait_sat), 32'(esat));
    if (eg1) begin
      chk("mem_we_p1", 32'(mem_we), 32'(w1));
      chk("mem_addr_p1", mem_addr, a1);
      chk("mem_wdata_p1", mem_wdata, d1);
      chk("mem_type_p1", 32'(mem_type), 32'(type1));
    end else if (eg0) begin
      chk("mem_we_p0", 32'(mem_we), 32'(w0));
      chk("mem_addr_p0", mem_addr, a0);
      chk("mem_wdata_p0", mem_wdata, d0);
      chk("mem_type_p0", 32'(mem_type), 32'(type0));
    end else begin
      chk("mem_idle_fields", {mem_addr ^ mem_wdata} | 32'(mem_type) | 32'(mem_we) | mem_addr, 32'h0);
    end
    chk("rvalid0", 32'(rvalid0), 32'(pend0));
    chk("rvalid1", 32'(rvalid1), 32'(pend1));
    if (rvalid0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      chk("rdata0", rdata0, e);
    end else if (!rvalid0) begin
      chk("rdata0_idle", rdata0, 32'h0);
    end
    if (rvalid1 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      chk("rdata1", rdata1, e);
    end else if (!rvalid1) begin
      chk("rdata1_idle", rdata1, 32'h0);
    end
    pend0 = eg0 && !w0 && push;
    pend1 = eg1 && !w1 && push;
    if (pend0) exp_q0.push_back(ref_mem[a0[9:2]]);
    if (pend1) exp_q1.push_back(ref_mem[a1[9:2]]);
    if (eg0 && w0) ref_mem[a0[9:2]] = d0;
    if (eg1 && w1) ref_mem[a1[9:2]] = d1;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Preload one word while reset holds; both ports request to show no grant leaks.
  task automatic preload(input logic [7:0] idx, input logic [W-1:0] dat);
    pl_we = 1'b1; pl_idx = idx; pl_dat = dat;
    ref_mem[idx] = dat;
    step(1, 0, 32'h0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    pl_we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    checks = 0; errors = 0; pend0 = 1'b0; pend1 = 1'b0;
    pl_we = 1'b0; pl_idx = '0; pl_dat = '0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; type0 = TYPE_W;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; type1 = TYPE_HU;
    #2 rst = 1'b0;
    @(negedge CLK);

    // Reset state with both requests high, memory preload
    preload(8'd0, 32'hA0A0_0001);
    preload(8'd1, 32'hB1B1_0002);
    preload(8'd2, 32'hC2C2_0003);
    preload(8'd4, 32'hDEAD_BEEF);

    // Release: first grant in the first cycle out of reset; single load 0x10
    rst = 1'b1;
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle();

    // Conflict: gnt0 x4, forced gnt1 with wait_sat, then port 0 resumes
    for (int i = 0; i < MW; i++) step(1, 0, 32'h0, 0, 1, 0, 32'h10, 0, 1, 0, 0, 1);
    step(1, 0, 32'h0, 0, 1, 0, 32'h10, 0, 0, 1, 1, 1);
    step(1, 0, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle();

    // Back-to-back: port 1 store then port 0 load of the same address
    step(0, 0, 0, 0, 1, 1, 32'h20, 32'h0000_0055, 0, 1, 0, 1);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle();

    // Pipelined loads, no bubbles
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle();
    idle();

    // Reset mid-load: the port-1 load's rvalid must never appear
    step(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 1, 0, 0);
    rst = 1'b0;
    step(1, 0, 32'h0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 1, 0, 1);
    idle();

    // Idle, then a withdrawn port-1 request: count holds at 2 while req1 is low,
    // so the forced grant comes after only two further losses
    idle();
    idle();
    step(1, 0, 32'h0, 0, 1, 0, 32'h8, 0, 1, 0, 0, 1);
    step(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 32'h0, 0, 1, 0, 32'h8, 0, 1, 0, 0, 1);
    step(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 1, 0, 0, 1);
    step(1, 0, 32'h8, 0, 1, 0, 32'h8, 0, 0, 1, 1, 1);
    step(1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle();
    idle();

    // Every expected load return must have been consumed
    chk("exp_q0_drained", 32'(exp_q0.size()), 32'h0);
    chk("exp_q1_drained", 32'(exp_q1.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single data memory behind the CPU's load/store path between the CPU (port 0) and a debug/program-loader master (port 1). It sits between the CPU's ALU-result/RD2/Type/MemWrite signals and the data-memory array. Port 0 normally has fixed priority, and a starvation counter forces a port-1 grant after a bounded wait. It issues one access per cycle to a memory with 1-cycle synchronous read latency and routes read data back to the issuing port.

## Interface
- WIDTH, 32, data and address width
- MAX_WAIT, 4, conflicting cycles port 1 may lose before it is forced to win; legal range 1..15
- CLK  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request; must stay high with fields stable until granted
- we0, we1  in  1  1 = store, 0 = load
- addr0, addr1  in  WIDTH  byte address
- wdata0, wdata1  in  WIDTH  store data
- type0, type1  in  3  access type (byte/half/word, signed/unsigned), same encoding as the CPU Type field
- gnt0, gnt1  out  1  access issued this cycle (combinational from req and state)
- rvalid0, rvalid1  out  1  load data valid (registered, one cycle after the load's gnt)
- rdata0, rdata1  out  WIDTH  load data, qualified by rvalid
- mem_en  out  1  memory access this cycle
- mem_we, mem_addr, mem_wdata, mem_type  out  1/WIDTH/WIDTH/3  fields muxed from the granted port
- mem_rdata  in  WIDTH  read data, valid the cycle after mem_en && !mem_we
- wait_sat  out  1  starvation counter at MAX_WAIT (debug visibility)

## Operation
- Grant rule for one cycle:
  - neither port requesting -> no grant
  - one port requesting -> that port
  - both requesting -> port 0, unless wait_cnt == MAX_WAIT, in which case port 1
- gnt0 and gnt1 are never both high; at most one grant per cycle.
- mem_en = gnt0 | gnt1. When mem_en = 0, all mem_* fields are driven to 0.
- wait_cnt (4-bit):
  - +1 on each cycle req1 && !gnt1
  - saturates at MAX_WAIT
  - clears on gnt1
  - holds when req1 = 0
- Read return tracking uses registers rd_pend and rd_owner, both set at the load's grant:
  - the next cycle raises rvalid[rd_owner]
  - rdata[rd_owner] = mem_rdata
  - the other port's rdata = 0
- Stores produce no rvalid; gnt is the completion indication.
- A port may be granted back-to-back. The next grant may coincide with the previous load's rvalid, giving full throughput.
- Read-after-write to the same address in consecutive cycles returns the new data; the memory is write-first, and the arbiter adds no forwarding.
- If req is dropped before gnt (protocol violation), the arbiter never grants it and stays consistent; wait_cnt holds.

## Timing
- Reset (rst low, asynchronous): wait_cnt = 0, rd_pend = 0, rd_owner = 0. While rst is low:
  - gnt0/gnt1, mem_en, rvalid0/rvalid1, wait_sat are forced to 0
  - rdata0/rdata1 = 0
- Reset asserted with a load outstanding: the rvalid is dropped and never appears after release.
- First grant is possible in the first cycle rst is high.
- Latency:
  - request to grant: 0 cycles when uncontended
  - load: gnt cycle N -> rvalid cycle N+1
  - port 1 worst case under continuous port-0 traffic: grant on its MAX_WAIT+1-th requesting cycle
- Forced port-1 grant delays port 0 by exactly one cycle.

## Structure
- Package mem_arb_pkg holds:
  - the port index enum (PORT_CPU = 0, PORT_DBG = 1)
  - the 3-bit access-type localparams shared with the memory unit
- One sub-module, mem_arb_starve_cnt: saturating counter with inputs inc, clr, sat_val and outputs cnt, sat.
- The top level holds the grant logic, field muxing and the read-return registers.

## Test plan
- Single-port load: req0 load to 0x10 where memory holds 0xDEADBEEF -> gnt0 in cycle N; rvalid0 = 1 with rdata0 = 0xDEADBEEF in N+1; rvalid1 = 0.
- Conflict with MAX_WAIT = 4, req0 and req1 both held high -> gnt0 for cycles 0-3, gnt1 in cycle 4 (wait_sat = 1 in that cycle), wait_cnt = 0 in cycle 5, gnt0 resumes.
- Back-to-back: port 1 stores 0x00000055 to 0x20 in cycle N, port 0 loads 0x20 in N+1 -> rvalid0 with 0x00000055 in N+2; exactly one access per cycle on mem_en.
- Pipelined loads on port 0 to 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rvalid0 pulses with the matching data, no bubbles.
- Reset mid-load: drop rst in the cycle after gnt1 for a load -> rvalid1 never asserts; wait_cnt = 0 after release; a fresh req1 is granted in the first cycle after release.
- Idle, and a req1 pulse withdrawn before grant while req0 is busy -> gnt1 never rises; wait_cnt holds its value while req1 is low.
